// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Define MD_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 6-9).
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             new_mul, new_div;

  // Products over 2*WIDTH bits from extended operands; low half of the wide product is exact.
  logic [2*WIDTH-1:0] sprod, uprod;
  assign sprod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign uprod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // One unsigned divider serves both DIV (on magnitudes) and DIVU.
  logic             a_neg, b_neg, is_sdiv;
  logic [WIDTH-1:0] div_n, div_d, div_d_nz, uq, ur, quo, rem;
  assign is_sdiv  = (op_q == OP_DIV);
  assign a_neg    = is_sdiv & a_q[WIDTH-1];
  assign b_neg    = is_sdiv & b_q[WIDTH-1];
  assign div_n    = a_neg ? ('0 - a_q) : a_q;
  assign div_d    = b_neg ? ('0 - b_q) : b_q;
  assign div_d_nz = (div_d == '0) ? WIDTH'(1) : div_d;
  assign uq       = div_n / div_d_nz;
  assign ur       = div_n % div_d_nz;
  assign quo      = (a_neg ^ b_neg) ? ('0 - uq) : uq;
  assign rem      = a_neg ? ('0 - ur) : ur;

`ifdef MD_MADD_EN
  logic [2*WIDTH-1:0] acc_add, acc_sub;
  assign acc_add = {hi_q, lo_q} + ((op_q == OP_MADD) ? sprod : uprod);
  assign acc_sub = {hi_q, lo_q} - ((op_q == OP_MSUB) ? sprod : uprod);
`endif

  always_comb begin
    new_mul = 1'b0;
    new_div = 1'b0;
    case (md_op)
      OP_MULT, OP_MULTU: new_mul = 1'b1;
      OP_DIV, OP_DIVU:   new_div = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: new_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q == '0) begin
      if (start) begin
        if (new_mul || new_div) begin
          a_d   = a;
          b_d   = b;
          op_d  = md_op;
          cnt_d = new_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        end else if (md_op == OP_MTHI) begin
          hi_d = a;
        end else if (md_op == OP_MTLO) begin
          lo_d = a;
        end
      end
    end else if (cnt_q == CntW'(1)) begin
      cnt_d = '0;
      case (op_q)
        OP_MULT:  {hi_d, lo_d} = sprod;
        OP_MULTU: {hi_d, lo_d} = uprod;
        OP_DIV, OP_DIVU: begin
          // Divide by zero leaves HI/LO untouched.
          if (b_q != '0) begin
            lo_d = quo;
            hi_d = rem;
          end
        end
`ifdef MD_MADD_EN
        OP_MADD, OP_MADDU: {hi_d, lo_d} = acc_add;
        OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc_sub;
`endif
        default: ;
      endcase
    end else begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized self-checking bench for md_unit against a 64-bit arithmetic model.
// Honours MD_MADD_EN the same way as the design.
module tb_md_unit;

  localparam int unsigned MultCycles = 5;
  localparam int unsigned DivCycles  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(MultCycles),
    .DIV_CYCLES (DivCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // New {hi,lo} from the architectural rules, using 64-bit integer arithmetic.
  function automatic logic [63:0] ref_hilo(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] cur);
    longint     sx = longint'($signed(x));
    longint     sy = longint'($signed(y));
    logic [63:0] ux = {32'd0, x};
    logic [63:0] uy = {32'd0, y};
    case (op)
      4'd0: return 64'(sx * sy);
      4'd1: return ux * uy;
      4'd2: return (y == 0) ? cur : {32'(sx % sy), 32'(sx / sy)};
      4'd3: return (y == 0) ? cur : {32'(ux % uy), 32'(ux / uy)};
      4'd4: return {x, cur[31:0]};
      4'd5: return {cur[63:32], x};
`ifdef MD_MADD_EN
      4'd6: return cur + 64'(sx * sy);
      4'd7: return cur + ux * uy;
      4'd8: return cur - 64'(sx * sy);
      4'd9: return cur - ux * uy;
`endif
      default: return cur;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: return MultCycles;
      4'd2, 4'd3: return DivCycles;
`ifdef MD_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: return MultCycles;
`endif
      default: return 0;
    endcase
  endfunction

  // Issue one op while idle; count busy cycles and check HI/LO while busy and at the fall.
  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] expv;
    int          lat;
    int          n;
    expv  = ref_hilo(op, x, y, {m_hi, m_lo});
    lat   = ref_lat(op);
    start = 1'b1;
    md_op = op;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      vectors++;
      if ({hi, lo} !== {m_hi, m_lo}) begin
        miscompares++;
        $display("FAIL hold_while_busy op=%0d cyc=%0d got=%h expected=%h", op, n, {hi, lo},
                 {m_hi, m_lo});
      end
      n++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (n != lat) begin
      miscompares++;
      $display("FAIL busy_len op=%0d got=%0d expected=%0d", op, n, lat);
    end
    vectors++;
    if (hi !== expv[63:32]) begin
      miscompares++;
      $display("FAIL hi op=%0d a=%h b=%h got=%h expected=%h", op, x, y, hi, expv[63:32]);
    end
    vectors++;
    if (lo !== expv[31:0]) begin
      miscompares++;
      $display("FAIL lo op=%0d a=%h b=%h got=%h expected=%h", op, x, y, lo, expv[31:0]);
    end
    m_hi = expv[63:32];
    m_lo = expv[31:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got=%b expected=0", busy);
    end
    vectors++;
    if ({hi, lo} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_hilo got=%h expected=0", {hi, lo});
    end
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_directed();
    do_op(4'd0, 32'hFFFF_FFFE, 32'd3);
    vectors++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      miscompares++;
      $display("FAIL mult_const got=%h expected=fffffffffffffffa", {hi, lo});
    end
    do_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vectors++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      miscompares++;
      $display("FAIL multu_const got=%h expected=fffffffe00000001", {hi, lo});
    end
    do_op(4'd2, 32'hFFFF_FFF9, 32'd2);
    vectors++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      miscompares++;
      $display("FAIL div_const got=%h expected=fffffffffffffffd", {hi, lo});
    end
    do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    vectors++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
      miscompares++;
      $display("FAIL div_intmin got=%h expected=0000000080000000", {hi, lo});
    end
  endtask

  task automatic test_div_by_zero();
    do_op(4'd4, 32'h11, 32'd0);
    do_op(4'd5, 32'h22, 32'd0);
    do_op(4'd3, 32'd7, 32'd0);
    vectors++;
    if ({hi, lo} !== 64'h0000_0011_0000_0022) begin
      miscompares++;
      $display("FAIL divu_zero got=%h expected=0000001100000022", {hi, lo});
    end
    do_op(4'd2, 32'hDEAD_BEEF, 32'd0);
  endtask

  task automatic test_mt();
    do_op(4'd5, 32'h1234, 32'd0);
    vectors++;
    if (lo !== 32'h1234) begin
      miscompares++;
      $display("FAIL mtlo_const got=%h expected=00001234", lo);
    end
    do_op(4'd4, 32'hCAFE_0001, 32'd0);
  endtask

  // Ops issued while a DIV is in flight must be ignored.
  task automatic test_start_while_busy();
    logic [63:0] expv;
    int          n;
    expv  = ref_hilo(4'd2, 32'd100, 32'd7, {m_hi, m_lo});
    start = 1'b1;
    md_op = 4'd2;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      start = (n == 3) || (n == 5) || (n == 7);
      md_op = (n == 3) ? 4'd4 : (n == 5) ? 4'd0 : 4'd5;
      a     = 32'd5;
      b     = 32'd9;
      @(posedge clk);
      #1;
      vectors++;
      if (busy === 1'b1 && {hi, lo} !== {m_hi, m_lo}) begin
        miscompares++;
        $display("FAIL busy_ignore cyc=%0d got=%h expected=%h", n, {hi, lo}, {m_hi, m_lo});
      end
    end
    start = 1'b0;
    vectors++;
    if (n != DivCycles) begin
      miscompares++;
      $display("FAIL busy_ignore_len got=%0d expected=%0d", n, DivCycles);
    end
    vectors++;
    if ({hi, lo} !== expv) begin
      miscompares++;
      $display("FAIL busy_ignore_commit got=%h expected=%h", {hi, lo}, expv);
    end
    m_hi = expv[63:32];
    m_lo = expv[31:0];
  endtask

  task automatic test_reset_mid_op();
    do_op(4'd4, 32'hAAAA_0000, 32'd0);
    do_op(4'd5, 32'h0000_5555, 32'd0);
    start = 1'b1;
    md_op = 4'd0;
    a     = 32'd1234;
    b     = 32'd5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
      miscompares++;
      $display("FAIL async_reset busy=%b hilo=%h expected busy=0 hilo=0", busy, {hi, lo});
    end
    #2;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    for (int i = 0; i < MultCycles + 2; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
        miscompares++;
        $display("FAIL no_commit_after_reset cyc=%0d busy=%b hilo=%h", i, busy, {hi, lo});
      end
    end
  endtask

  task automatic test_madd();
    do_op(4'd4, 32'd0, 32'd0);
    do_op(4'd5, 32'd10, 32'd0);
    do_op(4'd6, 32'd3, 32'd4);
`ifdef MD_MADD_EN
    vectors++;
    if ({hi, lo} !== 64'd22) begin
      miscompares++;
      $display("FAIL madd_const got=%h expected=0000000000000016", {hi, lo});
    end
`endif
    do_op(4'd8, 32'hFFFF_FFFF, 32'd7);
    do_op(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(4'd9, 32'h8000_0000, 32'd3);
    for (int op = 10; op < 16; op++) do_op(4'(op), $urandom, $urandom);
  endtask

  // Back-to-back random ops: each issues on the edge right after the previous one completes.
  task automatic test_random();
    logic [31:0] x, y;
    int          sel;
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 7));
      x   = $urandom;
      y   = $urandom;
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end else if (sel == 2) y = 32'($urandom_range(1, 20));
      else if (sel == 3) y = -32'($urandom_range(1, 20));
      do_op(4'($urandom_range(0, 15)), x, y);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_mt();
    test_start_while_busy();
    test_reset_mid_op();
    test_madd();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
